wide_add_sequencer: RTL and testbench

//  Multi-cycle wide adder/subtractor built around one shared 16-bit Kogge_Stone adder.

---
 rtl/ks_pkg.sv | 20 ++
 rtl/kogge_stone.sv | 52 +++++
 rtl/wide_add_sequencer.sv | 136 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// ks_pkg: shared definitions for the wide add/sub sequencer and its
// Kogge-Stone word adder.
//   WORD_W      - width of the shared adder (one operand word)
//   seq_state_t - sequencer FSM state encoding
//   cnt_width() - word-counter width, never below one bit
package ks_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kogge_stone.sv
// Kogge_Stone: parallel-prefix adder with carry-in.
// Ports:
//   a, b  in  WIDTH  addends
//   cin   in  1      carry-in
//   sum   out WIDTH  a + b + cin (mod 2^WIDTH)
//   cout  out 1      carry out of the MSB
module Kogge_Stone
  import ks_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);

  // g[l][i] / p[l][i]: group generate / propagate covering bits
  // [i : max(0, i-2^l+1)]; cin is folded into bit 0's generate so
  // g[LEVELS][i] is the carry into bit i+1.
  logic [LEVELS:0][WIDTH-1:0] g;
  logic [LEVELS:0][WIDTH-1:0] p;
  logic [WIDTH-1:0]           c;
  logic                       unused_p;

  assign p[0] = a ^ b;
  assign g[0] = (a & b) | {{(WIDTH-1){1'b0}}, (a[0] ^ b[0]) & cin};

  for (genvar lvl = 1; lvl <= LEVELS; lvl++) begin : g_lvl
    localparam int D = 1 << (lvl - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_merge
        assign g[lvl][i] = g[lvl-1][i] | (p[lvl-1][i] & g[lvl-1][i-D]);
        assign p[lvl][i] = p[lvl-1][i] & p[lvl-1][i-D];
      end else begin : g_pass
        assign g[lvl][i] = g[lvl-1][i];
        assign p[lvl][i] = p[lvl-1][i];
      end
    end
  end

  assign c    = {g[LEVELS][WIDTH-2:0], cin};
  assign sum  = p[0] ^ c;
  assign cout = g[LEVELS][WIDTH-1];

  // Upper-level propagate terms are only partly consumed by the prefix tree.
  assign unused_p = ^p;

endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: NWORDS*16-bit add/subtract computed one word per
// cycle (LSW first) through a single shared Kogge_Stone adder, carry
// chained through a register between words.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   op_a, op_b, sub      operands; sub=1 computes A-B
//   out_valid / out_ready result handshake (out_valid held until accepted)
//   result               W-bit sum/difference
//   carry_out            carry from MSB (sub: 1 = no borrow)
//   overflow             two's-complement overflow
module wide_add_sequencer
  import ks_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] op_a,
  input  logic [WORD_W*NWORDS-1:0] op_b,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] result,
  output logic                     carry_out,
  output logic                     overflow
);

  localparam int W  = WORD_W * NWORDS;
  localparam int CW = cnt_width(NWORDS);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;     // holds B already inverted for sub
  logic [W-1:0]  res_q, res_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          ovld_q, ovld_d;

  logic [WORD_W-1:0] word_a, word_b, ks_sum;
  logic              ks_cout;

  assign word_a = a_q[int'(cnt_q)*WORD_W +: WORD_W];
  assign word_b = b_q[int'(cnt_q)*WORD_W +: WORD_W];

  Kogge_Stone #(.WIDTH(WORD_W)) u_ks (
    .a    (word_a),
    .b    (word_b),
    .cin  (carry_q),
    .sum  (ks_sum),
    .cout (ks_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    ovld_d  = ovld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;           // +1 completes the two's-complement of B
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[int'(cnt_q)*WORD_W +: WORD_W] = ks_sum;
        carry_d = ks_cout;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = ks_cout;
          // carry into the MSB is a^b^sum at that bit; overflow when it
          // differs from the carry out of the MSB
          ovf_d   = ks_cout ^ (word_a[WORD_W-1] ^ word_b[WORD_W-1] ^ ks_sum[WORD_W-1]);
          ovld_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ovld_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      ovld_q  <= ovld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ovld_q;
  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // NWORDS=4 instance
  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, sub4 = 1'b0;
  logic [63:0] op_a4 = '0, op_b4 = '0;
  logic        in_ready4, out_valid4, cout4, ovf4;
  logic [63:0] result4;

  // NWORDS=1 instance
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0, sub1 = 1'b0;
  logic [15:0] op_a1 = '0, op_b1 = '0;
  logic        in_ready1, out_valid1, cout1, ovf1;
  logic [15:0] result1;

  int checks = 0;
  int errors = 0;

  wide_add_sequencer #(.NWORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .result(result4), .carry_out(cout4), .overflow(ovf4)
  );

  wide_add_sequencer #(.NWORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .sub(sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .result(result1), .carry_out(cout1), .overflow(ovf1)
  );

  // Issue one request to dut4 and count cycles until out_valid (bounded).
  task automatic start4(input logic [63:0] a, input logic [63:0] b, input logic s,
                        output int lat);
    int guard = 0;
    while (!in_ready4 && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!in_ready4) begin
      checks++; errors++;
      $display("FAIL start4_ready: in_ready=%0b required 1 after %0d cycles", in_ready4, guard);
    end
    in_valid4 = 1'b1; op_a4 = a; op_b4 = b; sub4 = s;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack4();
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready4, out_valid4, result4, cout4, ovf4} !== {1'b1, 1'b0, 64'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset4: rdy=%0b vld=%0b res=%h c=%0b v=%0b required 1 0 0 0 0",
               in_ready4, out_valid4, result4, cout4, ovf4);
    end
    checks++;
    if ({in_ready1, out_valid1, result1, cout1, ovf1} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset1: rdy=%0b vld=%0b res=%h c=%0b v=%0b required 1 0 0 0 0",
               in_ready1, out_valid1, result1, cout1, ovf1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_chain();
    int lat;
    start4(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL chain_latency: got %0d required 4", lat); end
    checks++;
    if ({result4, cout4, ovf4} !== {64'h0001_0000_0000_0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL chain_result: res=%h c=%0b v=%0b required 0001000000000000 0 0", result4, cout4, ovf4);
    end
    ack4();
    checks++;
    if ({out_valid4, in_ready4} !== 2'b01) begin
      errors++;
      $display("FAIL chain_ack: vld=%0b rdy=%0b required 0 1", out_valid4, in_ready4);
    end
  endtask

  task automatic test_sub_borrow();
    int lat;
    start4(64'h0, 64'h1, 1'b1, lat);
    checks++;
    if ({result4, cout4, ovf4} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow: res=%h c=%0b v=%0b required ffffffffffffffff 0 0", result4, cout4, ovf4);
    end
    ack4();
  endtask

  task automatic test_overflow();
    int lat;
    start4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++;
    if ({result4, cout4, ovf4} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_pos: res=%h c=%0b v=%0b required 8000000000000000 0 1", result4, cout4, ovf4);
    end
    ack4();
    start4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    checks++;
    if ({result4, cout4, ovf4} !== {64'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_wrap: res=%h c=%0b v=%0b required 0 1 0", result4, cout4, ovf4);
    end
    ack4();
  endtask

  task automatic test_backpressure();
    int lat;
    start4(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d required 4", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid4 = i[0];
      op_a4 = 64'hDEAD_0000_0000_0000 + 64'(i);
      op_b4 = 64'h5;
      sub4  = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid4, in_ready4, result4, cout4, ovf4} !==
          {1'b1, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%0b rdy=%0b res=%h c=%0b v=%0b required 1 0 23456789abcdf001 0 0",
                 i, out_valid4, in_ready4, result4, cout4, ovf4);
      end
    end
    in_valid4 = 1'b0;
    ack4();
    checks++;
    if ({out_valid4, in_ready4} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: vld=%0b rdy=%0b required 0 1", out_valid4, in_ready4);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    in_valid4 = 1'b1; op_a4 = 64'hAAAA_BBBB_CCCC_DDDD; op_b4 = 64'h1111_1111_1111_1111; sub4 = 1'b0;
    @(posedge clk); #1;           // accept
    in_valid4 = 1'b0;
    repeat (2) @(posedge clk);    // words 0 and 1 done, counter now 2
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({in_ready4, out_valid4, result4, cout4, ovf4} !== {1'b1, 1'b0, 64'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: rdy=%0b vld=%0b res=%h c=%0b v=%0b required 1 0 0 0 0",
               in_ready4, out_valid4, result4, cout4, ovf4);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid4 !== 1'b0) begin
        errors++;
        $display("FAIL mid_abort%0d: out_valid=%0b required 0", i, out_valid4);
      end
    end
    start4(64'h0123_4567_89AB_CDEF, 64'h1, 1'b1, lat);
    checks++;
    if ({lat[3:0], result4, cout4, ovf4} !== {4'd4, 64'h0123_4567_89AB_CDEE, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_recover: lat=%0d res=%h c=%0b v=%0b required 4 0123456789abcdee 1 0",
               lat, result4, cout4, ovf4);
    end
    ack4();
  endtask

  task automatic test_back_to_back();
    out_ready1 = 1'b1;
    in_valid1 = 1'b1; op_a1 = 16'hFFFF; op_b1 = 16'h0001; sub1 = 1'b0;
    @(posedge clk); #1;           // accept op 1
    op_a1 = 16'h1234; op_b1 = 16'h0234; sub1 = 1'b1;   // ignored until IDLE
    checks++;
    if ({out_valid1, in_ready1} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_run: vld=%0b rdy=%0b required 0 0", out_valid1, in_ready1);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid1, result1, cout1, ovf1} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_op1: vld=%0b res=%h c=%0b v=%0b required 1 0000 1 0", out_valid1, result1, cout1, ovf1);
    end
    @(posedge clk); #1;           // result handshake
    checks++;
    if ({out_valid1, in_ready1} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_idle: vld=%0b rdy=%0b required 0 1", out_valid1, in_ready1);
    end
    @(posedge clk); #1;           // accept op 2, three cycles after op 1
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid1, result1, cout1, ovf1} !== {1'b1, 16'h1000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_op2: vld=%0b res=%h c=%0b v=%0b required 1 1000 1 0", out_valid1, result1, cout1, ovf1);
    end
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    checks++;
    if ({out_valid1, in_ready1} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_end: vld=%0b rdy=%0b required 0 1", out_valid1, in_ready1);
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_sub_borrow();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
